// File: rtl/conv7x7_mac_core.sv
// 7x7 window x kernel MAC: 49 signed products, row sums, total, then round/shift/saturate to a pixel.
// Latency 4 edges from window capture to pix_valid, one window per cycle; no backpressure, windows outside READY are dropped.
module conv7x7_mac_core #(
   parameter int IMA   = 8,
   parameter int WGT   = 8,
   parameter int ACC   = 22,
   parameter int SHIFT = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [49*IMA-1:0]    ima_win,
   input  logic                 win_valid,
   input  logic                 win_first,
   input  logic                 win_last,
   input  logic                 wgt_start,
   input  logic                 wgt_valid,
   input  logic [WGT-1:0]       wgt_data,
   output logic                 core_ready,
   output logic [IMA-1:0]       pix_out,
   output logic [ACC-1:0]       acc_out,
   output logic                 pix_valid,
   output logic                 frame_start_out,
   output logic                 frame_end_out
);

   localparam int NTAP = 49;
   localparam int NROW = 7;
   localparam int PW   = IMA + WGT + 1;
   localparam int RND  = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
   localparam int PMAX = (1 << IMA) - 1;

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t                 state_q;
   logic [5:0]             idx_q;
   logic                   core_ready_q;
   logic signed [WGT-1:0]  wgt_q [NTAP];

   logic signed [PW-1:0]   prod_q [NTAP];
   logic signed [PW-1:0]   prod_d [NTAP];
   logic signed [ACC-1:0]  row_q  [NROW];
   logic signed [ACC-1:0]  row_d  [NROW];
   logic signed [ACC-1:0]  row_sum [NROW];
   logic signed [ACC-1:0]  tot_q, tot_d;
   logic [IMA-1:0]         pix_q, pix_d;
   logic [ACC-1:0]         acc_q, acc_d;
   logic [3:0]             vld_q, vld_d;
   logic [3:0]             first_q, first_d;
   logic [3:0]             last_q, last_d;

   logic                   accept;
   logic signed [ACC:0]    rnd_sum;
   logic signed [ACC:0]    shr_sum;
   logic [IMA-1:0]         sat_pix;

   function automatic logic signed [PW-1:0] tap_mul(input logic [IMA-1:0] p,
                                                    input logic signed [WGT-1:0] w);
      tap_mul = PW'(signed'({1'b0, p})) * PW'(w);
   endfunction

   // Kernel loader; a start pulse always wins and may carry weight 0 in the same beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         core_ready_q <= 1'b0;
         for (int k = 0; k < NTAP; k++) wgt_q[k] <= '0;
      end else begin
         if (wgt_start) begin
            state_q      <= LOAD;
            core_ready_q <= 1'b0;
            if (wgt_valid) begin
               wgt_q[0] <= wgt_data;
               idx_q    <= 6'd1;
            end else begin
               idx_q    <= '0;
            end
         end else if (state_q == LOAD && wgt_valid) begin
            wgt_q[idx_q] <= wgt_data;
            if (idx_q == 6'(NTAP - 1)) begin
               state_q      <= READY;
               core_ready_q <= 1'b1;
               idx_q        <= '0;
            end else begin
               idx_q <= idx_q + 6'd1;
            end
         end
      end
   end

   assign accept = win_valid && (state_q == READY);

   always_comb begin
      for (int k = 0; k < NTAP; k++) begin
         prod_d[k] = accept ? tap_mul(ima_win[k*IMA +: IMA], wgt_q[k]) : prod_q[k];
      end

      for (int r = 0; r < NROW; r++) begin
         row_sum[r] = '0;
         for (int c = 0; c < NROW; c++) begin
            row_sum[r] = row_sum[r] + ACC'(prod_q[r*NROW + c]);
         end
         row_d[r] = vld_q[0] ? row_sum[r] : row_q[r];
      end

      tot_d = tot_q;
      if (vld_q[1]) begin
         tot_d = '0;
         for (int r = 0; r < NROW; r++) tot_d = tot_d + row_q[r];
      end

      // Floor shift after adding half an LSB gives round-half-up.
      rnd_sum = (ACC+1)'(tot_q) + (ACC+1)'(RND);
      shr_sum = rnd_sum >>> SHIFT;
      if (shr_sum[ACC]) begin
         sat_pix = '0;
      end else if (shr_sum > (ACC+1)'(PMAX)) begin
         sat_pix = '1;
      end else begin
         sat_pix = shr_sum[IMA-1:0];
      end

      pix_d   = vld_q[2] ? sat_pix : pix_q;
      acc_d   = vld_q[2] ? tot_q   : acc_q;
      vld_d   = {vld_q[2:0],   accept};
      first_d = {first_q[2:0], accept & win_first};
      last_d  = {last_q[2:0],  accept & win_last};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAP; k++) prod_q[k] <= '0;
         for (int r = 0; r < NROW; r++) row_q[r] <= '0;
         tot_q   <= '0;
         pix_q   <= '0;
         acc_q   <= '0;
         vld_q   <= '0;
         first_q <= '0;
         last_q  <= '0;
      end else begin
         prod_q  <= prod_d;
         row_q   <= row_d;
         tot_q   <= tot_d;
         pix_q   <= pix_d;
         acc_q   <= acc_d;
         vld_q   <= vld_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign core_ready      = core_ready_q;
   assign pix_out         = pix_q;
   assign acc_out         = acc_q;
   assign pix_valid       = vld_q[3];
   assign frame_start_out = first_q[3];
   assign frame_end_out   = last_q[3];

endmodule

// File: tb/tb_conv7x7_mac_core.sv
// Randomized bench for conv7x7_mac_core against an arithmetic convolution model.
module tb_conv7x7_mac_core;

   localparam int SHIFT = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [391:0]  ima_win;
   logic          win_valid, win_first, win_last;
   logic          wgt_start, wgt_valid;
   logic [7:0]    wgt_data;
   logic          core_ready;
   logic [7:0]    pix_out;
   logic [21:0]   acc_out;
   logic          pix_valid, frame_start_out, frame_end_out;

   int total = 0;
   int bad   = 0;
   int mdl_w   [49];
   int ld_w    [49];
   int mdl_pix [49];

   conv7x7_mac_core #(.IMA(8), .WGT(8), .ACC(22), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst_n(rst_n), .ima_win(ima_win),
      .win_valid(win_valid), .win_first(win_first), .win_last(win_last),
      .wgt_start(wgt_start), .wgt_valid(wgt_valid), .wgt_data(wgt_data),
      .core_ready(core_ready), .pix_out(pix_out), .acc_out(acc_out),
      .pix_valid(pix_valid), .frame_start_out(frame_start_out),
      .frame_end_out(frame_end_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_acc();
      int s = 0;
      for (int k = 0; k < 49; k++) s += mdl_pix[k] * mdl_w[k];
      return s;
   endfunction

   function automatic int model_pix(input int a);
      int r;
      r = a + (2**SHIFT) / 2;
      r = r >>> SHIFT;
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   task automatic set_win();
      for (int k = 0; k < 49; k++) ima_win[k*8 +: 8] = 8'(mdl_pix[k]);
   endtask

   task automatic rand_pix();
      for (int k = 0; k < 49; k++) mdl_pix[k] = int'($urandom_range(255, 0));
      set_win();
   endtask

   task automatic rand_ldw();
      for (int k = 0; k < 49; k++) ld_w[k] = int'($urandom_range(255, 0)) - 128;
   endtask

   task automatic load_weights();
      wgt_start = 1'b1;
      wgt_valid = 1'b1;
      wgt_data  = 8'(ld_w[0]);
      tick();
      wgt_start = 1'b0;
      for (int k = 1; k < 49; k++) begin
         wgt_data = 8'(ld_w[k]);
         tick();
      end
      wgt_valid = 1'b0;
      mdl_w = ld_w;
   endtask

   task automatic drive_win(input logic f, input logic l);
      win_valid = 1'b1;
      win_first = f;
      win_last  = l;
      tick();
      win_valid = 1'b0;
      win_first = 1'b0;
      win_last  = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
      total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL reset_core_ready got %b want 0", core_ready); end
      total++; if (acc_out !== 22'd0) begin bad++; $display("FAIL reset_acc_out got %0d want 0", acc_out); end
      total++; if (pix_out !== 8'd0) begin bad++; $display("FAIL reset_pix_out got %0d want 0", pix_out); end
      total++; if ({frame_start_out, frame_end_out} !== 2'b00) begin bad++; $display("FAIL reset_frame_flags got %b want 00", {frame_start_out, frame_end_out}); end
      rand_pix();
      drive_win(1'b1, 1'b1);
      repeat (5) begin
         tick();
         total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL idle_drop got %b want 0", pix_valid); end
      end
   endtask

   task automatic test_ones();
      int ea, ep;
      for (int k = 0; k < 49; k++) ld_w[k] = 1;
      load_weights();
      total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL ones_ready got %b want 1", core_ready); end
      for (int k = 0; k < 49; k++) mdl_pix[k] = 255;
      set_win();
      ea = model_acc();
      ep = model_pix(ea);
      drive_win(1'b1, 1'b0);
      tick(); tick();
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL ones_early_valid got %b want 0", pix_valid); end
      tick();
      total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL ones_valid got %b want 1", pix_valid); end
      total++; if (int'($signed(acc_out)) !== ea) begin bad++; $display("FAIL ones_acc got %0d want %0d", $signed(acc_out), ea); end
      total++; if (int'(pix_out) !== ep) begin bad++; $display("FAIL ones_pix got %0d want %0d", pix_out, ep); end
      total++; if ({frame_start_out, frame_end_out} !== 2'b10) begin bad++; $display("FAIL ones_flags got %b want 10", {frame_start_out, frame_end_out}); end
      tick();
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL ones_valid_drop got %b want 0", pix_valid); end
      total++; if (int'(pix_out) !== ep) begin bad++; $display("FAIL ones_hold got %0d want %0d", pix_out, ep); end
   endtask

   task automatic test_center();
      int ea, ep;
      for (int k = 0; k < 49; k++) ld_w[k] = (k == 24) ? 127 : 0;
      load_weights();
      for (int t = 0; t < 5; t++) begin
         for (int k = 0; k < 49; k++)
            mdl_pix[k] = (k == 24) ? 200 : ((t == 0) ? 99 : int'($urandom_range(255, 0)));
         set_win();
         ea = model_acc();
         ep = model_pix(ea);
         drive_win(1'b0, 1'b0);
         tick(); tick(); tick();
         total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL center_valid[%0d] got %b want 1", t, pix_valid); end
         total++; if (int'($signed(acc_out)) !== ea) begin bad++; $display("FAIL center_acc[%0d] got %0d want %0d", t, $signed(acc_out), ea); end
         total++; if (int'(pix_out) !== ep) begin bad++; $display("FAIL center_pix[%0d] got %0d want %0d", t, pix_out, ep); end
      end
   endtask

   task automatic test_extremes();
      int ea, ep;
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 49; k++) begin
            case (t)
               0: begin ld_w[k] = -1;   mdl_pix[k] = 10;  end
               1: begin ld_w[k] = 127;  mdl_pix[k] = 255; end
               2: begin ld_w[k] = -128; mdl_pix[k] = 255; end
               default: begin
                  ld_w[k]    = int'($urandom_range(255, 0)) - 128;
                  mdl_pix[k] = int'($urandom_range(255, 0));
               end
            endcase
         end
         load_weights();
         set_win();
         ea = model_acc();
         ep = model_pix(ea);
         drive_win(1'b0, 1'b0);
         tick(); tick(); tick();
         total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL ext_valid[%0d] got %b want 1", t, pix_valid); end
         total++; if (int'($signed(acc_out)) !== ea) begin bad++; $display("FAIL ext_acc[%0d] got %0d want %0d", t, $signed(acc_out), ea); end
         total++; if (int'(pix_out) !== ep) begin bad++; $display("FAIL ext_pix[%0d] got %0d want %0d", t, pix_out, ep); end
      end
   endtask

   task automatic test_back_to_back();
      int     exp_acc[$];
      logic   exp_f[$];
      logic   exp_l[$];
      int     nout, first_c, last_c, ea;
      logic   ef, el;
      nout = 0; first_c = -1; last_c = -1;
      rand_ldw();
      load_weights();
      rand_ldw();
      for (int c = 0; c < 60; c++) begin
         win_valid = 1'b0; win_first = 1'b0; win_last = 1'b0;
         wgt_start = 1'b0; wgt_valid = 1'b0;
         if (c < 5) begin
            rand_pix();
            win_valid = 1'b1;
            win_first = (c == 0);
            win_last  = (c == 4);
            exp_acc.push_back(model_acc());
            exp_f.push_back(c == 0);
            exp_l.push_back(c == 4);
         end
         if (c == 5) begin
            wgt_start = 1'b1; wgt_valid = 1'b1; wgt_data = 8'(ld_w[0]);
         end
         if (c > 5 && c < 54) begin
            wgt_valid = 1'b1; wgt_data = 8'(ld_w[c-5]);
         end
         tick();
         if (pix_valid) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            nout++;
            if (exp_acc.size() > 0) begin
               ea = exp_acc.pop_front();
               ef = exp_f.pop_front();
               el = exp_l.pop_front();
               total++; if (int'($signed(acc_out)) !== ea) begin bad++; $display("FAIL b2b_acc[%0d] got %0d want %0d", nout, $signed(acc_out), ea); end
               total++; if (int'(pix_out) !== model_pix(ea)) begin bad++; $display("FAIL b2b_pix[%0d] got %0d want %0d", nout, pix_out, model_pix(ea)); end
               total++; if ({frame_start_out, frame_end_out} !== {ef, el}) begin bad++; $display("FAIL b2b_flags[%0d] got %b want %b", nout, {frame_start_out, frame_end_out}, {ef, el}); end
            end
         end else begin
            total++; if ({frame_start_out, frame_end_out} !== 2'b00) begin bad++; $display("FAIL b2b_flag_no_valid got %b want 00", {frame_start_out, frame_end_out}); end
         end
      end
      wgt_valid = 1'b0;
      mdl_w = ld_w;
      total++; if (nout !== 5) begin bad++; $display("FAIL b2b_count got %0d want 5", nout); end
      total++; if (last_c - first_c !== 4) begin bad++; $display("FAIL b2b_span got %0d want 4", last_c - first_c); end
      total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL b2b_reload_ready got %b want 1", core_ready); end
      rand_pix();
      ea = model_acc();
      drive_win(1'b1, 1'b1);
      tick(); tick(); tick();
      total++; if (int'($signed(acc_out)) !== ea) begin bad++; $display("FAIL b2b_new_wgt_acc got %0d want %0d", $signed(acc_out), ea); end
      total++; if ({pix_valid, frame_start_out, frame_end_out} !== 3'b111) begin bad++; $display("FAIL b2b_single_frame got %b want 111", {pix_valid, frame_start_out, frame_end_out}); end
   endtask

   task automatic test_load_drop();
      int   b[49];
      int   ea;
      logic seen;
      rand_ldw();
      for (int k = 0; k < 49; k++) b[k] = int'($urandom_range(255, 0)) - 128;
      for (int c = 0; c < 70; c++) begin
         wgt_start = (c == 0) || (c == 20);
         wgt_valid = (c != 20);
         wgt_data  = (c < 20) ? 8'(ld_w[c]) : ((c > 20) ? 8'(b[c-21]) : 8'h00);
         win_valid = (c >= 5 && c < 15);
         win_first = win_valid;
         win_last  = win_valid;
         if (win_valid) rand_pix();
         tick();
         total++; if (core_ready !== (c == 69)) begin bad++; $display("FAIL load_ready[%0d] got %b want %b", c, core_ready, (c == 69)); end
         total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL load_drop_valid[%0d] got %b want 0", c, pix_valid); end
      end
      wgt_start = 1'b0; wgt_valid = 1'b0;
      win_valid = 1'b0; win_first = 1'b0; win_last = 1'b0;
      seen = 1'b0;
      repeat (4) begin tick(); seen |= pix_valid; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL load_drop_late got %b want 0", seen); end
      mdl_w = b;
      rand_pix();
      ea = model_acc();
      drive_win(1'b0, 1'b0);
      tick(); tick(); tick();
      total++; if (int'($signed(acc_out)) !== ea) begin bad++; $display("FAIL load_restart_acc got %0d want %0d", $signed(acc_out), ea); end
   endtask

   task automatic test_reset_flight();
      logic seen;
      int   ea;
      rand_ldw();
      load_weights();
      for (int i = 0; i < 3; i++) begin rand_pix(); drive_win(i == 0, 1'b0); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 49; k++) mdl_w[k] = 0;
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_flight_valid got %b want 0", pix_valid); end
      total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL rst_flight_ready got %b want 0", core_ready); end
      total++; if (acc_out !== 22'd0) begin bad++; $display("FAIL rst_flight_acc got %0d want 0", acc_out); end
      seen = 1'b0;
      repeat (6) begin tick(); seen |= pix_valid | frame_start_out; end
      rand_pix();
      drive_win(1'b1, 1'b0);
      repeat (6) begin tick(); seen |= pix_valid | frame_start_out; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_flight_no_output got %b want 0", seen); end
      rand_ldw();
      load_weights();
      rand_pix();
      ea = model_acc();
      drive_win(1'b0, 1'b0);
      tick(); tick(); tick();
      total++; if ({pix_valid, int'($signed(acc_out))} !== {1'b1, ea}) begin bad++; $display("FAIL rst_recover got valid=%b acc=%0d want valid=1 acc=%0d", pix_valid, $signed(acc_out), ea); end
   endtask

   initial begin
      rst_n = 1'b0;
      ima_win = '0;
      win_valid = 1'b0; win_first = 1'b0; win_last = 1'b0;
      wgt_start = 1'b0; wgt_valid = 1'b0; wgt_data = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_ones();
      test_center();
      test_extremes();
      test_back_to_back();
      test_load_drop();
      test_reset_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
